apb_intercon_rr: RTL and testbench
==================================

# apb_intercon_rr

Parametrised multi-master APB interconnect with round-robin arbitration, a parameter-driven slave address map, and PSLVERR generation. Sits between the per-core APB master ports and the shared SoC peripheral slaves (GPIO, UART, REGS, BRAM). Owns the arbitration FSM, locks the grant for a whole transfer, and regenerates a clean SETUP/ACCESS sequence towards the slaves. Terminates transfers to unmapped addresses and transfers to hung slaves with an error response.

## Interface
Parameters:
- BUS_WIDTH, 16, address and data width.
- MASTER_PORTS, 4, number of master ports, 1 or more.
- SLAVE_PORTS, 6, number of slave ports, 1 or more.
- SLV_BASE, SoC map from config, packed SLAVE_PORTS*BUS_WIDTH; first address of each slave, slave i in bits [i*BUS_WIDTH +: BUS_WIDTH].
- SLV_LAST, SoC map from config, packed as SLV_BASE; last address of each slave, inclusive.
- TIMEOUT, 255, maximum cycles spent in ACCESS; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  master addresses.
- S_PWRITE, S_PSELx, S_PENABLE  in  MASTER_PORTS  master controls.
- S_PWDATA  in  MASTER_PORTS*BUS_WIDTH  master write data.
- S_PRDATA  out  MASTER_PORTS*BUS_WIDTH  read data back to the masters.
- S_PREADY, S_PSLVERR  out  MASTER_PORTS  per-master completion and error.
- M_PADDR, M_PWDATA  out  BUS_WIDTH  registered; driven to all slaves.
- M_PWRITE, M_PENABLE  out  1  registered.
- M_PSELx  out  SLAVE_PORTS  one-hot registered slave select.
- M_PRDATA  in  SLAVE_PORTS*BUS_WIDTH  read data from each slave.
- M_PREADY  in  SLAVE_PORTS  ready from each slave.

## Operation
- Master i is requesting while S_PSELx[i]=1.
- FSM states and transitions:
  - IDLE: on any request, the arbiter picks the first requester after last_grant (wrapping), latches grant, PADDR, PWRITE and PWDATA, and decodes the address. On a hit go to SETUP; on a miss go to ERROR.
  - SETUP: M_PSELx is one-hot and M_PENABLE=0. Always go to ACCESS.
  - ACCESS: M_PENABLE=1. On the selected slave's M_PREADY: S_PREADY[grant]=1, S_PRDATA[grant] = that slave's M_PRDATA, S_PSLVERR=0, then go to DONE. On the timeout instead: S_PREADY[grant]=1, S_PSLVERR[grant]=1, S_PRDATA=0, then go to DONE.
  - ERROR: S_PREADY[grant]=1 and S_PSLVERR[grant]=1 for one cycle; no M_PSELx is driven. Go to DONE.
  - DONE: M_PSELx=0 and M_PENABLE=0. last_grant is set to grant. Go to IDLE. This one-cycle bubble lets the finished master drop or restart its request.
- Address decode: a slave is hit when SLV_BASE[i] <= addr <= SLV_LAST[i]. If ranges overlap, the lowest index wins.
- Timeout counter: BUS_WIDTH bits wide, cleared on entry to ACCESS, incremented each ACCESS cycle without ready. It fires when the count equals TIMEOUT-1.
- S_PREADY, S_PSLVERR and S_PRDATA are combinational from the state and grant. They are 0 for every non-granted master and 0 outside the response cycle.
- Non-granted masters stall in their own ACCESS phase with PREADY low. Their signals are never forwarded.
- Reset values: state=IDLE, last_grant=MASTER_PORTS-1 (so master 0 wins first), all M_* outputs 0, all S_* outputs 0, counter 0.
- Reset mid-transfer: the next cycle is IDLE with M_PSELx=0. No response is issued to the interrupted master.

## Timing
- Idle bus, zero-wait slave: S_PSELx rises in cycle N. SETUP is in N+1. ACCESS and S_PREADY are in N+2. DONE is in N+3. The next grant can occur at N+4.
- Slave wait states: each cycle M_PREADY is low adds one cycle to the N+2 response.
- Unmapped address: ERROR and S_PREADY+S_PSLVERR are in N+1.
- Timeout: the error response comes in the TIMEOUT-th ACCESS cycle.
- Fairness: with all masters requesting continuously, each master is granted once every MASTER_PORTS transfers.
- A request that drops while the master is waiting (protocol violation) is ignored. The latched transfer still completes.
- MASTER_PORTS=1: the arbiter degenerates to always granting master 0. The grant register is still present, with a width of at least 1 bit.

## Structure
- Default SLV_BASE/SLV_LAST values, built from the existing DEF_MMU_*_S/_E and APB_PSELX_* constants, belong in the shared SoC config include. State encodings go there too.
- Sub-module apb_rr_arbiter, parametrised by MASTER_PORTS.
  - Inputs: req, last_grant, clk, reset.
  - Outputs: grant index and a valid flag.
- The address decode is a generate loop inside this block.

## Test plan
- Map for tests: slave0 0x0000–0x00FF, slave1 0x0100–0x01FF, TIMEOUT=8, MASTER_PORTS=4.
- Master0 writes 0xBEEF to 0x0010, zero-wait slave -> M_PSELx=01 in N+1. M_PENABLE=1 and S_PREADY[0]=1 in N+2. Slave0 captures 0xBEEF. PSLVERR=0.
- Master2 reads 0x0104, slave1 holds PREADY low 3 cycles and returns 0x1234 -> S_PREADY[2] and S_PRDATA[2]=0x1234 in N+5. All other S_PRDATA are 0.
- Masters 0–3 request simultaneously from reset -> grant order is 0,1,2,3. Then master1 and master3 re-request -> order is 1,3.
- Master1 accesses 0x0800 -> no M_PSELx. S_PREADY[1]=S_PSLVERR[1]=1 in N+1.
- Slave0 never readies -> S_PSLVERR[0]=1 on the 8th ACCESS cycle. M_PSELx=0 next cycle. A following transfer by master1 succeeds.
- Assert reset during ACCESS -> all M_* and S_* outputs are 0 the next cycle. Master0 is granted first after reset.

Source files
------------

// File: rtl/apb_intercon_rr_pkg.sv
// Shared definitions for the round-robin APB interconnect: FSM encoding,
// default SoC slave map and an index-width helper.
package apb_intercon_rr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERROR  = 3'd3,
    ST_DONE   = 3'd4
  } apb_state_e;

  localparam int DEF_BUS_WIDTH   = 32'sd16;
  localparam int DEF_SLAVE_PORTS = 32'sd6;

  localparam int APB_PSELX_GPIO  = 32'sd0;
  localparam int APB_PSELX_UART  = 32'sd1;
  localparam int APB_PSELX_REGS  = 32'sd2;
  localparam int APB_PSELX_BRAM  = 32'sd3;
  localparam int APB_PSELX_TIMER = 32'sd4;
  localparam int APB_PSELX_SPI   = 32'sd5;

  localparam logic [15:0] DEF_MMU_GPIO_S  = 16'h0000;
  localparam logic [15:0] DEF_MMU_GPIO_E  = 16'h00FF;
  localparam logic [15:0] DEF_MMU_UART_S  = 16'h0100;
  localparam logic [15:0] DEF_MMU_UART_E  = 16'h01FF;
  localparam logic [15:0] DEF_MMU_REGS_S  = 16'h0200;
  localparam logic [15:0] DEF_MMU_REGS_E  = 16'h02FF;
  localparam logic [15:0] DEF_MMU_BRAM_S  = 16'h1000;
  localparam logic [15:0] DEF_MMU_BRAM_E  = 16'h1FFF;
  localparam logic [15:0] DEF_MMU_TIMER_S = 16'h2000;
  localparam logic [15:0] DEF_MMU_TIMER_E = 16'h20FF;
  localparam logic [15:0] DEF_MMU_SPI_S   = 16'h2100;
  localparam logic [15:0] DEF_MMU_SPI_E   = 16'h21FF;

  // Concatenation order follows the APB_PSELX_* indices, highest first.
  localparam logic [DEF_SLAVE_PORTS*DEF_BUS_WIDTH-1:0] DEF_SLV_BASE = {
    DEF_MMU_SPI_S, DEF_MMU_TIMER_S, DEF_MMU_BRAM_S,
    DEF_MMU_REGS_S, DEF_MMU_UART_S, DEF_MMU_GPIO_S
  };
  localparam logic [DEF_SLAVE_PORTS*DEF_BUS_WIDTH-1:0] DEF_SLV_LAST = {
    DEF_MMU_SPI_E, DEF_MMU_TIMER_E, DEF_MMU_BRAM_E,
    DEF_MMU_REGS_E, DEF_MMU_UART_E, DEF_MMU_GPIO_E
  };

  function automatic int idx_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/apb_intercon_rr_arbiter.sv
// Round-robin pick of the first requesting master after last_grant,
// wrapping around; purely combinational so a grant lands in the request cycle.
module apb_rr_arbiter
  import apb_intercon_rr_pkg::*;
#(
  parameter int MASTER_PORTS = 32'sd4,
  localparam int GW = idx_width(MASTER_PORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MASTER_PORTS-1:0] req,
  input  logic [GW-1:0]           last_grant,
  output logic [GW-1:0]           grant,
  output logic                    valid
);

  int idx_v;

  // clk/reset belong to the shared arbiter interface; the pick itself holds no state.
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ reset;

  // Scan from last_grant+1 so every requester is reached within MASTER_PORTS grants.
  always_comb begin
    grant = last_grant;
    valid = 1'b0;
    idx_v = 32'sd0;
    for (int i = 32'sd1; i <= MASTER_PORTS; i++) begin
      idx_v = (int'(last_grant) + i) % MASTER_PORTS;
      if (!valid && req[idx_v]) begin
        grant = GW'(idx_v);
        valid = 1'b1;
      end else begin
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/apb_intercon_rr.sv
// Multi-master APB interconnect: round-robin grant locked per transfer,
// parameter-driven slave decode, error response for unmapped and hung slaves.
module apb_intercon_rr
  import apb_intercon_rr_pkg::*;
#(
  parameter int BUS_WIDTH    = 32'sd16,
  parameter int MASTER_PORTS = 32'sd4,
  parameter int SLAVE_PORTS  = 32'sd6,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLV_LAST = DEF_SLV_LAST,
  parameter int TIMEOUT      = 32'sd255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  output logic                              M_PWRITE,
  output logic                              M_PENABLE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY
);

  localparam int GW = idx_width(MASTER_PORTS);
  localparam int SW = idx_width(SLAVE_PORTS);
  localparam bit TO_EN = (TIMEOUT != 32'sd0);
  localparam logic [BUS_WIDTH-1:0] TO_LAST = BUS_WIDTH'(TIMEOUT - 32'sd1);
  localparam logic [BUS_WIDTH-1:0] CNT_ONE = BUS_WIDTH'(32'd1);

  apb_state_e             state_r;
  logic [GW-1:0]          grant_r;
  logic [GW-1:0]          last_grant_r;
  logic [SW-1:0]          sel_idx_r;
  logic [BUS_WIDTH-1:0]   paddr_r;
  logic [BUS_WIDTH-1:0]   pwdata_r;
  logic                   pwrite_r;
  logic                   penable_r;
  logic [SLAVE_PORTS-1:0] psel_r;
  logic [BUS_WIDTH-1:0]   cnt_r;

  logic [GW-1:0]          arb_grant_s;
  logic                   arb_valid_s;
  logic [BUS_WIDTH-1:0]   arb_addr_s;
  logic [SLAVE_PORTS-1:0] hit_s;
  logic [SW-1:0]          dec_idx_s;
  logic                   dec_hit_s;
  logic                   sel_ready_s;
  logic [BUS_WIDTH-1:0]   sel_prdata_s;
  logic                   timeout_s;
  logic                   resp_s;
  logic                   err_s;
  logic [BUS_WIDTH-1:0]   rdata_s;

  // Masters' own PENABLE is not needed: the access phase is regenerated here.
  logic unused_penable_s;
  assign unused_penable_s = ^S_PENABLE;

  apb_rr_arbiter #(
    .MASTER_PORTS(MASTER_PORTS)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (S_PSELx),
    .last_grant(last_grant_r),
    .grant     (arb_grant_s),
    .valid     (arb_valid_s)
  );

  assign arb_addr_s = S_PADDR[int'(arb_grant_s)*BUS_WIDTH +: BUS_WIDTH];

  for (genvar j = 0; j < SLAVE_PORTS; j++) begin : g_decode
    assign hit_s[j] = (arb_addr_s >= SLV_BASE[j*BUS_WIDTH +: BUS_WIDTH]) &&
                      (arb_addr_s <= SLV_LAST[j*BUS_WIDTH +: BUS_WIDTH]);
  end

  // Descending scan so the lowest-index slave wins on overlapping ranges.
  always_comb begin
    dec_idx_s = '0;
    dec_hit_s = 1'b0;
    for (int j = SLAVE_PORTS - 32'sd1; j >= 32'sd0; j--) begin
      if (hit_s[j]) begin
        dec_idx_s = SW'(j);
        dec_hit_s = 1'b1;
      end else begin
        dec_idx_s = dec_idx_s;
      end
    end
  end

  assign sel_ready_s  = M_PREADY[sel_idx_r];
  assign sel_prdata_s = M_PRDATA[int'(sel_idx_r)*BUS_WIDTH +: BUS_WIDTH];
  assign timeout_s    = TO_EN && (cnt_r == TO_LAST);

  // Response cycle: slave ready takes priority over a coincident timeout.
  always_comb begin
    resp_s  = 1'b0;
    err_s   = 1'b0;
    rdata_s = '0;
    case (state_r)
      ST_ACCESS: begin
        if (sel_ready_s) begin
          resp_s  = 1'b1;
          rdata_s = sel_prdata_s;
        end else if (timeout_s) begin
          resp_s = 1'b1;
          err_s  = 1'b1;
        end else begin
          resp_s = 1'b0;
        end
      end
      ST_ERROR: begin
        resp_s = 1'b1;
        err_s  = 1'b1;
      end
      default: begin
        resp_s = 1'b0;
      end
    endcase
  end

  // Route the response to the granted master only.
  always_comb begin
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    if (resp_s) begin
      S_PREADY[grant_r]  = 1'b1;
      S_PSLVERR[grant_r] = err_s;
      S_PRDATA[int'(grant_r)*BUS_WIDTH +: BUS_WIDTH] = rdata_s;
    end else begin
      S_PREADY = '0;
    end
  end

  // Transfer FSM; grant and slave-side signals stay latched for the whole transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= GW'(MASTER_PORTS - 32'sd1);
      sel_idx_r    <= '0;
      paddr_r      <= '0;
      pwdata_r     <= '0;
      pwrite_r     <= 1'b0;
      penable_r    <= 1'b0;
      psel_r       <= '0;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            grant_r   <= arb_grant_s;
            paddr_r   <= arb_addr_s;
            pwdata_r  <= S_PWDATA[int'(arb_grant_s)*BUS_WIDTH +: BUS_WIDTH];
            pwrite_r  <= S_PWRITE[arb_grant_s];
            sel_idx_r <= dec_idx_s;
            if (dec_hit_s) begin
              psel_r            <= '0;
              psel_r[dec_idx_s] <= 1'b1;
              state_r           <= ST_SETUP;
            end else begin
              state_r <= ST_ERROR;
            end
          end
        end
        ST_SETUP: begin
          penable_r <= 1'b1;
          cnt_r     <= '0;
          state_r   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready_s || timeout_s) begin
            psel_r    <= '0;
            penable_r <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_ERROR: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          last_grant_r <= grant_r;
          state_r      <= ST_IDLE;
        end
        default: begin
          psel_r    <= '0;
          penable_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign M_PADDR   = paddr_r;
  assign M_PWDATA  = pwdata_r;
  assign M_PWRITE  = pwrite_r;
  assign M_PENABLE = penable_r;
  assign M_PSELx   = psel_r;

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Scoreboard bench for apb_intercon_rr: 4 masters, 2 behavioural slaves
// (0x0000-0x00FF, 0x0100-0x01FF), TIMEOUT=8.
module tb_apb_intercon_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [3:0]  S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, S_PSLVERR;
  logic [15:0] M_PADDR, M_PWDATA;
  logic        M_PWRITE, M_PENABLE;
  logic [1:0]  M_PSELx, M_PREADY;
  logic [31:0] M_PRDATA;

  apb_intercon_rr #(
    .BUS_WIDTH   (16),
    .MASTER_PORTS(4),
    .SLAVE_PORTS (2),
    .SLV_BASE    (32'h0100_0000),
    .SLV_LAST    (32'h01FF_00FF),
    .TIMEOUT     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .S_PADDR  (S_PADDR),
    .S_PWRITE (S_PWRITE),
    .S_PSELx  (S_PSELx),
    .S_PENABLE(S_PENABLE),
    .S_PWDATA (S_PWDATA),
    .S_PRDATA (S_PRDATA),
    .S_PREADY (S_PREADY),
    .S_PSLVERR(S_PSLVERR),
    .M_PADDR  (M_PADDR),
    .M_PWDATA (M_PWDATA),
    .M_PWRITE (M_PWRITE),
    .M_PENABLE(M_PENABLE),
    .M_PSELx  (M_PSELx),
    .M_PRDATA (M_PRDATA),
    .M_PREADY (M_PREADY)
  );

  always #5 clk = ~clk;

  // Behavioural slaves: fixed read value, configurable wait states, write capture.
  int          cyc = 0;
  int          acc_cnt = 0;
  int          wait_cfg [2];
  logic [15:0] rd_val [2];
  logic [15:0] last_wr_addr [2] = '{16'h0000, 16'h0000};
  logic [15:0] last_wr_data [2] = '{16'h0000, 16'h0000};

  always_comb begin
    M_PRDATA = {rd_val[1], rd_val[0]};
    for (int j = 0; j < 2; j++)
      M_PREADY[j] = M_PSELx[j] & M_PENABLE & (acc_cnt >= wait_cfg[j]);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (M_PENABLE && !(|(M_PSELx & M_PREADY))) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    for (int j = 0; j < 2; j++)
      if (M_PSELx[j] && M_PENABLE && M_PREADY[j] && M_PWRITE) begin
        last_wr_addr[j] <= M_PADDR;
        last_wr_data[j] <= M_PWDATA;
      end
  end

  typedef struct {
    int          master;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int m, input logic [15:0] rdata, input logic err, input int at);
    exp_t e;
    e.master = m; e.rdata = rdata; e.err = err; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic issue(input int m, input logic [15:0] addr, input logic wr, input logic [15:0] data);
    S_PSELx[m] = 1'b1;
    S_PENABLE[m] = 1'b0;
    S_PWRITE[m] = wr;
    S_PADDR[m*16 +: 16] = addr;
    S_PWDATA[m*16 +: 16] = data;
  endtask

  // Advance to the next falling edge, score any response and release its master.
  task automatic tick();
    exp_t e;
    logic [3:0]  exp_rdy;
    logic [63:0] exp_rd;
    @(negedge clk);
    if (|S_PREADY) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", S_PREADY, 64'h0);
      end else begin
        e = sb.pop_front();
        exp_rdy = 4'b0000;
        exp_rdy[e.master] = 1'b1;
        exp_rd = 64'h0;
        exp_rd[e.master*16 +: 16] = e.rdata;
        check("resp_master", S_PREADY, exp_rdy);
        check("resp_cycle", cyc, e.cyc);
        check("resp_err", S_PSLVERR, e.err ? exp_rdy : 4'b0000);
        check("resp_rdata", S_PRDATA, exp_rd);
      end
      S_PSELx = S_PSELx & ~S_PREADY;
    end
    S_PENABLE = S_PSELx;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drain", sb.size(), 64'h0);
    sb.delete();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected run to end earlier");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int n;
    reset = 1'b1;
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    wait_cfg[0] = 0; wait_cfg[1] = 0;
    rd_val[0] = 16'hA0A0; rd_val[1] = 16'hB1B1;
    tick();
    tick();
    check("rst_psel", M_PSELx, 64'h0);
    check("rst_penable", M_PENABLE, 64'h0);
    check("rst_paddr", M_PADDR, 64'h0);
    check("rst_pwdata", M_PWDATA, 64'h0);
    check("rst_pwrite", M_PWRITE, 64'h0);
    check("rst_pready", S_PREADY, 64'h0);
    check("rst_prdata", S_PRDATA, 64'h0);
    reset = 1'b0;

    // All four masters at once: grants 0,1,2,3, four cycles apart.
    c = cyc;
    issue(0, 16'h0000, 1'b0, 16'h0);
    issue(1, 16'h0104, 1'b0, 16'h0);
    issue(2, 16'h0020, 1'b0, 16'h0);
    issue(3, 16'h01A0, 1'b0, 16'h0);
    push_exp(0, 16'hA0A0, 1'b0, c + 2);
    push_exp(1, 16'hB1B1, 1'b0, c + 6);
    push_exp(2, 16'hA0A0, 1'b0, c + 10);
    push_exp(3, 16'hB1B1, 1'b0, c + 14);
    drain(40);

    // Masters 1 and 3 again after last_grant=3: order 1,3.
    c = cyc;
    issue(3, 16'h0000, 1'b0, 16'h0);
    issue(1, 16'h0100, 1'b0, 16'h0);
    push_exp(1, 16'hB1B1, 1'b0, c + 2);
    push_exp(3, 16'hA0A0, 1'b0, c + 6);
    drain(20);

    // Master0 write 0xBEEF to 0x0010, zero-wait slave0.
    c = cyc;
    issue(0, 16'h0010, 1'b1, 16'hBEEF);
    push_exp(0, 16'hA0A0, 1'b0, c + 2);
    tick();
    check("wr_setup_psel", M_PSELx, 64'h1);
    check("wr_setup_penable", M_PENABLE, 64'h0);
    check("wr_setup_paddr", M_PADDR, 64'h0010);
    check("wr_setup_pwdata", M_PWDATA, 64'hBEEF);
    check("wr_setup_pwrite", M_PWRITE, 64'h1);
    tick();
    check("wr_access_penable", M_PENABLE, 64'h1);
    check("wr_access_psel", M_PSELx, 64'h1);
    tick();
    check("wr_done_psel", M_PSELx, 64'h0);
    check("wr_slave_data", last_wr_data[0], 64'hBEEF);
    check("wr_slave_addr", last_wr_addr[0], 64'h0010);
    drain(5);

    // Master2 read 0x0104, slave1 three wait states, data 0x1234 at N+5.
    rd_val[1] = 16'h1234;
    wait_cfg[1] = 3;
    c = cyc;
    issue(2, 16'h0104, 1'b0, 16'h0);
    push_exp(2, 16'h1234, 1'b0, c + 5);
    drain(20);
    wait_cfg[1] = 0;

    // Master1 to unmapped 0x0800: error in N+1, no slave select.
    c = cyc;
    issue(1, 16'h0800, 1'b1, 16'h5555);
    push_exp(1, 16'h0000, 1'b1, c + 1);
    tick();
    check("unmap_psel", M_PSELx, 64'h0);
    drain(10);

    // Slave0 never ready: error on 8th ACCESS cycle, bus idle next cycle.
    wait_cfg[0] = 1000;
    c = cyc;
    issue(0, 16'h0030, 1'b0, 16'h0);
    push_exp(0, 16'h0000, 1'b1, c + 9);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("to_drained", sb.size(), 64'h0);
    tick();
    check("to_done_psel", M_PSELx, 64'h0);
    check("to_done_penable", M_PENABLE, 64'h0);
    wait_cfg[0] = 0;
    tick();
    c = cyc;
    issue(1, 16'h0110, 1'b0, 16'h0);
    push_exp(1, 16'h1234, 1'b0, c + 2);
    drain(20);

    // Reset during ACCESS: everything zero next cycle, then master0 wins first.
    wait_cfg[0] = 5;
    issue(0, 16'h0020, 1'b1, 16'h5A5A);
    tick();
    tick();
    check("mid_in_access", M_PENABLE, 64'h1);
    reset = 1'b1;
    S_PSELx = '0;
    S_PENABLE = '0;
    tick();
    check("mid_rst_psel", M_PSELx, 64'h0);
    check("mid_rst_penable", M_PENABLE, 64'h0);
    check("mid_rst_paddr", M_PADDR, 64'h0);
    check("mid_rst_pwdata", M_PWDATA, 64'h0);
    check("mid_rst_pwrite", M_PWRITE, 64'h0);
    check("mid_rst_pready", S_PREADY, 64'h0);
    check("mid_rst_pslverr", S_PSLVERR, 64'h0);
    check("mid_rst_prdata", S_PRDATA, 64'h0);
    reset = 1'b0;
    wait_cfg[0] = 0;
    c = cyc;
    issue(2, 16'h0050, 1'b0, 16'h0);
    issue(0, 16'h0040, 1'b0, 16'h0);
    push_exp(0, 16'hA0A0, 1'b0, c + 2);
    push_exp(2, 16'hA0A0, 1'b0, c + 6);
    drain(20);
    check("no_stray_write", last_wr_data[0], 64'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
